// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the frame-buffer write port between the
// pattern generator (0) and live video (1), round-robin with bounded bursts.
module fb_write_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 48,
  parameter int MAX_BURST = 16
) (
  input  logic              clk24,
  input  logic              rst_n,
  input  logic              en0,
  input  logic              en1,
  input  logic              s0_valid,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s0_ready,
  output logic              s1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_we,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] cnt;
  logic       last;

  logic req0;
  logic req1;
  logic xfer0;
  logic xfer1;
  logic own_xfer;
  logic own_req;
  logic oth_req;
  logic at_limit;
  logic keep;
  logic enter;

  assign req0 = s0_valid & en0;
  assign req1 = s1_valid & en1;

  // ready depends only on the state register and the enable
  assign s0_ready = (state == GNT0) & en0;
  assign s1_ready = (state == GNT1) & en1;

  assign xfer0 = s0_valid & s0_ready;
  assign xfer1 = s1_valid & s1_ready;

  assign grant = {state == GNT1, state == GNT0};

  // at most one source can be ready, so any transfer is the owner's
  assign own_xfer = xfer0 | xfer1;
  assign own_req  = (state == GNT1) ? req1 : req0;
  assign oth_req  = (state == GNT1) ? req0 : req1;
  assign at_limit = own_xfer & (cnt == LAST_BEAT);
  assign keep     = own_xfer & ~at_limit;

  // a fresh grant clears the beat counter, including burst re-entry
  assign enter = (nxt != IDLE) & ~keep;

  // choose the next owner: stay mid-burst, else hand over, else re-enter
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) begin
      if (req0 & req1) begin
        nxt = last ? GNT0 : GNT1;
      end else if (req0) begin
        nxt = GNT0;
      end else if (req1) begin
        nxt = GNT1;
      end
    end else if (keep) begin
      nxt = state;
    end else if (oth_req) begin
      nxt = (state == GNT0) ? GNT1 : GNT0;
    end else if (at_limit & own_req) begin
      nxt = state;
    end
  end

  // arbitration state, beat counter and round-robin pointer
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      last  <= 1'b1;
    end else begin
      state <= nxt;
      if (enter) begin
        cnt  <= 8'd0;
        last <= (nxt == GNT1);
      end else if (keep) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // registered write port; address and data hold between writes
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
    end else begin
      mem_we <= xfer0 | xfer1;
      if (xfer0) begin
        mem_addr <= s0_addr;
        mem_dout <= s0_data;
      end else if (xfer1) begin
        mem_addr <= s1_addr;
        mem_dout <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: table vectors plus scoreboarded sequences
// against a cycle model of the two-source write arbiter.
module tb_fb_write_arbiter;

  localparam int AW = 19;
  localparam int DW = 48;
  localparam int MB = 16;

  logic          clk24 = 1'b0;
  logic          rst_n = 1'b0;
  logic          en0, en1, s0_valid, s1_valid;
  logic [AW-1:0] s0_addr, s1_addr, mem_addr;
  logic [DW-1:0] s0_data, s1_data, mem_dout;
  logic          s0_ready, s1_ready, mem_we;
  logic [1:0]    grant;

  fb_write_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk24(clk24), .rst_n(rst_n),
    .en0(en0), .en1(en1),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_addr(s0_addr), .s1_addr(s1_addr),
    .s0_data(s0_data), .s1_data(s1_data),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_we(mem_we), .grant(grant)
  );

  always #5 clk24 = ~clk24;

  typedef struct {
    int            cyc;
    logic [7:0]    tag;
    logic [AW-1:0] addr;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic v0, v1, e0, e1;
    logic r0, r1;
    logic [1:0] g;
  } vec_t;

  exp_t expq[$];
  wr_t  wlog[$];

  int ncmp = 0;
  int nbad = 0;
  int cyc  = 0;
  int n0   = 0;
  int n1   = 0;

  int            m_st, m_last, m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic       g_r0, g_r1;
  logic [1:0] g_gnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_last = 1;
    m_cnt  = 0;
    m_addr = '0;
    m_data = '0;
    expq.delete();
  endtask

  function automatic logic [7:0] tag_at(input int j);
    if (j < wlog.size()) return wlog[j].tag;
    return 8'hFF;
  endfunction

  // breaks in the write-cycle sequence within wlog[lo..hi]
  function automatic int gaps(input int lo, input int hi);
    int g = 0;
    for (int j = lo + 1; j <= hi && j < wlog.size(); j++)
      if (wlog[j].cyc != wlog[j-1].cyc + 1) g++;
    return g;
  endfunction

  function automatic void drive_data();
    s0_addr = AW'(n0);
    s0_data = {8'hA0, 21'd0, AW'(n0)};
    s1_addr = AW'(32'h70000 + n1);
    s1_data = {8'hB1, 21'd0, AW'(32'h70000 + n1)};
  endfunction

  // called at a falling edge; returns at the next falling edge
  task automatic tick(input logic v0, input logic v1,
                      input logic e0, input logic e1);
    logic q0, q1, r0, r1, t0, t1;
    logic tk, qk, qo, stay, hs0, hs1;
    int   nx;
    exp_t e;
    s0_valid = v0;
    s1_valid = v1;
    en0 = e0;
    en1 = e1;
    drive_data();
    #1;
    r0 = (m_st == 1) && e0;
    r1 = (m_st == 2) && e1;
    g_r0 = s0_ready;
    g_r1 = s1_ready;
    g_gnt = grant;
    chk("ready0", s0_ready, r0);
    chk("ready1", s1_ready, r1);
    chk("grant", grant, {m_st == 2, m_st == 1});
    hs0 = v0 & s0_ready;
    hs1 = v1 & s1_ready;
    q0 = v0 & e0;
    q1 = v1 & e1;
    t0 = v0 & r0;
    t1 = v1 & r1;
    if (t0) begin
      e.addr = s0_addr;
      e.data = s0_data;
      expq.push_back(e);
    end
    if (t1) begin
      e.addr = s1_addr;
      e.data = s1_data;
      expq.push_back(e);
    end
    tk = 0; qk = 0; qo = 0; stay = 0; nx = 0;
    if (m_st == 0) begin
      if (q0 && q1) nx = (m_last == 1) ? 1 : 2;
      else if (q0) nx = 1;
      else if (q1) nx = 2;
    end else begin
      tk = (m_st == 1) ? t0 : t1;
      qk = (m_st == 1) ? q0 : q1;
      qo = (m_st == 1) ? q1 : q0;
      if (tk && (m_cnt + 1 < MB)) begin
        nx = m_st;
        stay = 1;
      end else if (qo) nx = 3 - m_st;
      else if (tk && qk) nx = m_st;
      else nx = 0;
    end
    @(posedge clk24);
    cyc++;
    if (stay) m_cnt = m_cnt + 1;
    else if (nx != 0) begin
      m_cnt = 0;
      m_last = nx - 1;
    end
    m_st = nx;
    if (t0) begin
      m_addr = s0_addr;
      m_data = s0_data;
    end else if (t1) begin
      m_addr = s1_addr;
      m_data = s1_data;
    end
    if (hs0) n0++;
    if (hs1) n1++;
    #1;
    chk("mem_we", mem_we, t0 | t1);
    if (mem_we) begin
      if (expq.size() == 0) begin
        chk("write_expected", 1'b0, 1'b1);
      end else begin
        e = expq.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_dout, e.data);
      end
      wlog.push_back('{cyc, mem_dout[47:40], mem_addr});
    end else begin
      chk("hold_addr", mem_addr, m_addr);
      chk("hold_data", mem_dout, m_data);
    end
    @(negedge clk24);
  endtask

  // holds reset for two edges with the given valids, then releases
  task automatic do_reset(input logic v);
    rst_n = 1'b0;
    s0_valid = v;
    s1_valid = v;
    en0 = 1'b1;
    en1 = 1'b1;
    n0 = 0;
    n1 = 0;
    drive_data();
    model_reset();
    repeat (2) @(negedge clk24);
    chk("rst_grant", grant, 2'b00);
    chk("rst_ready0", s0_ready, 1'b0);
    chk("rst_ready1", s1_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_dout", mem_dout, '0);
    rst_n = 1'b1;
    wlog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic e1_prev;
    logic saw0;
    tbl[0]  = '{1, 1, 1, 1, 0, 0, 2'b00};
    tbl[1]  = '{1, 1, 1, 1, 1, 0, 2'b01};
    tbl[2]  = '{0, 1, 1, 1, 1, 0, 2'b01};
    tbl[3]  = '{0, 1, 1, 1, 0, 1, 2'b10};
    tbl[4]  = '{0, 1, 1, 0, 0, 0, 2'b10};
    tbl[5]  = '{0, 0, 1, 1, 0, 0, 2'b00};
    tbl[6]  = '{1, 1, 1, 1, 0, 0, 2'b00};
    tbl[7]  = '{0, 0, 1, 1, 1, 0, 2'b01};
    tbl[8]  = '{0, 1, 1, 1, 0, 0, 2'b00};
    tbl[9]  = '{1, 1, 0, 1, 0, 1, 2'b10};
    tbl[10] = '{1, 0, 0, 1, 0, 1, 2'b10};
    tbl[11] = '{0, 0, 1, 1, 0, 0, 2'b00};

    // reset with both valid, then the hand-derived vector table
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].v0, tbl[i].v1, tbl[i].e0, tbl[i].e1);
      chk("tbl_ready0", g_r0, tbl[i].r0);
      chk("tbl_ready1", g_r1, tbl[i].r1);
      chk("tbl_grant", g_gnt, tbl[i].g);
    end

    // single source, 40-beat stream across two burst boundaries
    do_reset(1'b0);
    for (int c = 0; c < 80 && n0 < 40; c++) tick(1, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("stream_count", wlog.size(), 40);
    for (int j = 0; j < wlog.size() && j < 40; j++)
      chk("stream_addr", wlog[j].addr, j);
    chk("stream_gaps", gaps(0, 39), 0);

    // contention: alternating 16-beat bursts starting with source 0
    do_reset(1'b0);
    for (int c = 0; c < 80 && wlog.size() < 48; c++) tick(1, 1, 1, 1);
    chk("cont_count", wlog.size() >= 48, 1);
    for (int j = 0; j < 48; j++)
      chk("cont_src", tag_at(j), ((j / 16) % 2 == 0) ? 8'hA0 : 8'hB1);
    chk("cont_gaps", gaps(0, 47), 0);

    // source 1 drops valid after 5 beats while source 0 waits
    do_reset(1'b0);
    for (int c = 0; c < 30; c++)
      tick(c > 0, (n1 < 5) || (n0 >= 1), 1, 1);
    chk("drop_count", wlog.size() >= 22, 1);
    for (int j = 0; j < 5; j++) chk("drop_s1", tag_at(j), 8'hB1);
    for (int j = 5; j < 21; j++) chk("drop_s0", tag_at(j), 8'hA0);
    chk("drop_next_s1", tag_at(21), 8'hB1);
    chk("drop_dead", gaps(4, 5), 1);
    chk("drop_gaps", gaps(0, 4) + gaps(5, 21), 0);

    // en0 low blocks source 0; en1 falls after 7 beats of source 1
    do_reset(1'b0);
    e1_prev = 1'b1;
    saw0 = 1'b0;
    for (int c = 0; c < 25; c++) begin
      logic e1;
      e1 = (n1 < 7);
      tick(1, 1, 0, e1);
      if (g_r0) saw0 = 1'b1;
      if (e1_prev && !e1) begin
        chk("en1_fall_ready", g_r1, 1'b0);
        chk("en1_fall_grant", g_gnt, 2'b10);
      end
      e1_prev = e1;
    end
    chk("en0_never_ready", saw0, 1'b0);
    chk("en_count", wlog.size(), 7);
    for (int j = 0; j < 7; j++) chk("en_src", tag_at(j), 8'hB1);

    // reset asserted during beat 9 of a source 0 burst
    do_reset(1'b0);
    for (int c = 0; c < 20 && n0 < 8; c++) tick(1, 0, 1, 1);
    s0_valid = 1'b1;
    drive_data();
    #1;
    chk("mid_we_before", mem_we, 1'b1);
    chk("mid_ready_before", s0_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_we", mem_we, 1'b0);
    chk("mid_grant", grant, 2'b00);
    chk("mid_ready0", s0_ready, 1'b0);
    chk("mid_addr", mem_addr, '0);
    chk("mid_dout", mem_dout, '0);
    model_reset();
    @(posedge clk24);
    #1;
    chk("mid_no_write", mem_we, 1'b0);
    @(negedge clk24);
    rst_n = 1'b1;
    wlog.delete();
    tick(1, 1, 1, 1);
    tick(1, 1, 1, 1);
    chk("mid_restart_r0", g_r0, 1'b1);
    chk("mid_restart_r1", g_r1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
